// File: rtl/conn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : conn_pkg                                                  |
// | Brief    : Shared FSM state type and default limits for conn_mode_ctrl|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package conn_pkg;

    typedef enum logic [1:0] {
        STABLE = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } state_t;

    localparam int c_max_outst_def = 16;
    localparam int c_drain_tmo_def = 1024;

endpackage
`default_nettype wire

// File: rtl/conn_mode_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : conn_mode_ctrl_if                                         |
// | Brief    : CSR mode request, XHB handshakes and controller outputs   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface conn_mode_ctrl_if #(
    parameter int MAX_OUTST = conn_pkg::c_max_outst_def
) ();
    localparam int CW = $clog2(MAX_OUTST + 1);

    logic          MODE_REQ_i;
    logic          ARVALID_i;
    logic          ARREADY_i;
    logic          RVALID_i;
    logic          RREADY_i;
    logic          RLAST_i;
    logic          AWVALID_i;
    logic          AWREADY_i;
    logic          BVALID_i;
    logic          BREADY_i;
    logic          ENABLE_o;
    logic          BLOCK_o;
    logic          MODE_ACK_o;
    logic [CW-1:0] RD_CNT_o;
    logic [CW-1:0] WR_CNT_o;
    logic          ERR_o;

    modport slave (
        input  MODE_REQ_i, ARVALID_i, ARREADY_i, RVALID_i, RREADY_i, RLAST_i,
        input  AWVALID_i, AWREADY_i, BVALID_i, BREADY_i,
        output ENABLE_o, BLOCK_o, MODE_ACK_o, RD_CNT_o, WR_CNT_o, ERR_o
    );

    modport master (
        output MODE_REQ_i, ARVALID_i, ARREADY_i, RVALID_i, RREADY_i, RLAST_i,
        output AWVALID_i, AWREADY_i, BVALID_i, BREADY_i,
        input  ENABLE_o, BLOCK_o, MODE_ACK_o, RD_CNT_o, WR_CNT_o, ERR_o
    );
endinterface
`default_nettype wire

// File: rtl/conn_outst_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : conn_outst_cnt                                            |
// | Brief    : Saturating outstanding-burst counter with sticky error    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module conn_outst_cnt #(
    parameter int MAX_OUTST = conn_pkg::c_max_outst_def,
    parameter int CW        = $clog2(MAX_OUTST + 1)
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          inc,
    input  wire logic          dec,
    output logic      [CW-1:0] cnt,
    output logic               err
);
    localparam logic [CW-1:0] c_max = CW'(MAX_OUTST);

    logic [CW-1:0] r_cnt;
    logic          r_err;

    // Simultaneous inc and dec cancel; overflow and underflow hold and flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else if (inc && !dec) begin
            if (r_cnt == c_max) r_err <= 1'b1;
            else                r_cnt <= r_cnt + CW'(1);
        end else if (dec && !inc) begin
            if (r_cnt == '0) r_err <= 1'b1;
            else             r_cnt <= r_cnt - CW'(1);
        end
    end

    assign cnt = r_cnt;
    assign err = r_err;
endmodule
`default_nettype wire

// File: rtl/conn_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : conn_mode_ctrl                                            |
// | Brief    : Drains outstanding XHB bursts before toggling compression |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module conn_mode_ctrl
    import conn_pkg::*;
#(
    parameter int MAX_OUTST = c_max_outst_def,
    parameter int DRAIN_TMO = c_drain_tmo_def
) (
    input wire logic  CLK_i,
    input wire logic  RSTN_i,
    conn_mode_ctrl_if.slave bus
);
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int TW = $clog2(DRAIN_TMO + 1);
    localparam logic [CW-1:0] c_cnt_max  = CW'(MAX_OUTST);
    localparam logic [TW-1:0] c_tmo_max  = TW'(DRAIN_TMO);
    localparam logic [TW-1:0] c_tmo_last = TW'(DRAIN_TMO - 1);

    logic          w_ar_hs, w_rl_hs, w_aw_hs, w_b_hs;
    logic [CW-1:0] w_rd_cnt, w_wr_cnt;
    logic          w_rd_err, w_wr_err;
    logic          w_mismatch, w_idle;
    state_t        r_state, w_next;
    logic          r_enable, r_ack, r_tmo_err;
    logic [TW-1:0] r_tmo_cnt;

    assign w_ar_hs    = bus.ARVALID_i & bus.ARREADY_i;
    assign w_rl_hs    = bus.RVALID_i & bus.RREADY_i & bus.RLAST_i;
    assign w_aw_hs    = bus.AWVALID_i & bus.AWREADY_i;
    assign w_b_hs     = bus.BVALID_i & bus.BREADY_i;
    assign w_mismatch = bus.MODE_REQ_i != r_enable;
    assign w_idle     = (w_rd_cnt == '0) && (w_wr_cnt == '0) && !w_ar_hs && !w_aw_hs;

    conn_outst_cnt #(.MAX_OUTST(MAX_OUTST), .CW(CW)) u_rd_cnt (
        .clk(CLK_i), .rst_n(RSTN_i), .inc(w_ar_hs), .dec(w_rl_hs),
        .cnt(w_rd_cnt), .err(w_rd_err)
    );

    conn_outst_cnt #(.MAX_OUTST(MAX_OUTST), .CW(CW)) u_wr_cnt (
        .clk(CLK_i), .rst_n(RSTN_i), .inc(w_aw_hs), .dec(w_b_hs),
        .cnt(w_wr_cnt), .err(w_wr_err)
    );

    always_ff @(posedge CLK_i or negedge RSTN_i) begin
        if (!RSTN_i) r_state <= STABLE;
        else         r_state <= w_next;
    end

    // A returning request aborts the drain before the idle check is considered.
    always_comb begin
        w_next = r_state;
        case (r_state)
            STABLE:  if (w_mismatch) w_next = DRAIN;
            DRAIN: begin
                if (!w_mismatch)  w_next = STABLE;
                else if (w_idle)  w_next = SWITCH;
            end
            SWITCH:  w_next = STABLE;
            default: w_next = STABLE;
        endcase
    end

    always_ff @(posedge CLK_i or negedge RSTN_i) begin
        if (!RSTN_i) begin
            r_enable  <= 1'b0;
            r_ack     <= 1'b0;
            r_tmo_err <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            r_ack <= (r_state == SWITCH);
            if (r_state == DRAIN && w_next == SWITCH) r_enable <= ~r_enable;
            if (r_state == DRAIN) begin
                if (w_next != DRAIN)             r_tmo_cnt <= '0;
                else if (r_tmo_cnt != c_tmo_max) r_tmo_cnt <= r_tmo_cnt + TW'(1);
                if (r_tmo_cnt == c_tmo_last)     r_tmo_err <= 1'b1;
            end else begin
                r_tmo_cnt <= '0;
            end
        end
    end

    assign bus.ENABLE_o   = r_enable;
    assign bus.MODE_ACK_o = r_ack;
    assign bus.BLOCK_o    = (r_state != STABLE) | (w_rd_cnt == c_cnt_max) | (w_wr_cnt == c_cnt_max);
    assign bus.RD_CNT_o   = w_rd_cnt;
    assign bus.WR_CNT_o   = w_wr_cnt;
    assign bus.ERR_o      = w_rd_err | w_wr_err | r_tmo_err;
endmodule
`default_nettype wire

// File: tb/tb_conn_mode_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_conn_mode_ctrl                                         |
// | Brief    : Directed bench with a cycle model for conn_mode_ctrl      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_conn_mode_ctrl;
    localparam int MAX = 16;
    localparam int TMO = 1024;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    conn_mode_ctrl_if #(.MAX_OUTST(MAX)) bus ();

    conn_mode_ctrl #(.MAX_OUTST(MAX), .DRAIN_TMO(TMO)) dut (
        .CLK_i(clk), .RSTN_i(rstn), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode switch tracked as "draining" / "switching" flags, counts as ints.
    int m_rd, m_wr, m_tmo;
    bit m_en, m_drain, m_switch, m_ack, m_err;

    always @(posedge clk or negedge rstn) begin : p_model
        bit ar, rl, aw, bh;
        int rd0, wr0;
        if (!rstn) begin
            m_rd = 0; m_wr = 0; m_tmo = 0;
            m_en = 0; m_drain = 0; m_switch = 0; m_ack = 0; m_err = 0;
        end else begin
            ar  = bus.ARVALID_i & bus.ARREADY_i;
            rl  = bus.RVALID_i & bus.RREADY_i & bus.RLAST_i;
            aw  = bus.AWVALID_i & bus.AWREADY_i;
            bh  = bus.BVALID_i & bus.BREADY_i;
            rd0 = m_rd;
            wr0 = m_wr;
            m_ack = m_switch;
            if (m_switch) begin
                m_switch = 0;
            end else if (m_drain) begin
                m_tmo++;
                if (m_tmo == TMO) m_err = 1;
                if (bus.MODE_REQ_i == m_en) begin
                    m_drain = 0; m_tmo = 0;
                end else if (rd0 == 0 && wr0 == 0 && !ar && !aw) begin
                    m_drain = 0; m_switch = 1; m_en = !m_en; m_tmo = 0;
                end
            end else if (bus.MODE_REQ_i != m_en) begin
                m_drain = 1;
            end
            if (ar && !rl) begin
                if (m_rd == MAX) m_err = 1; else m_rd++;
            end else if (rl && !ar) begin
                if (m_rd == 0) m_err = 1; else m_rd--;
            end
            if (aw && !bh) begin
                if (m_wr == MAX) m_err = 1; else m_wr++;
            end else if (bh && !aw) begin
                if (m_wr == 0) m_err = 1; else m_wr--;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mdl_enable", bus.ENABLE_o, m_en);
            chk("mdl_block",  bus.BLOCK_o,  m_drain | m_switch | (m_rd == MAX) | (m_wr == MAX));
            chk("mdl_ack",    bus.MODE_ACK_o, m_ack);
            chk("mdl_rd_cnt", bus.RD_CNT_o, m_rd);
            chk("mdl_wr_cnt", bus.WR_CNT_o, m_wr);
            chk("mdl_err",    bus.ERR_o,    m_err);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_hs();
        bus.ARVALID_i = 0; bus.ARREADY_i = 0;
        bus.RVALID_i  = 0; bus.RREADY_i  = 0; bus.RLAST_i = 0;
        bus.AWVALID_i = 0; bus.AWREADY_i = 0;
        bus.BVALID_i  = 0; bus.BREADY_i  = 0;
    endtask

    task automatic reset_with(input logic mode);
        rstn = 0;
        bus.MODE_REQ_i = mode;
        tick(1);
        rstn = 1;
        tick(1);
    endtask

    initial begin
        clear_hs();
        bus.MODE_REQ_i = 1;
        tick(2);
        mon_en = 1;
        chk("rst_enable", bus.ENABLE_o, 0);
        chk("rst_block",  bus.BLOCK_o,  0);
        chk("rst_rd_cnt", bus.RD_CNT_o, 0);
        chk("rst_err",    bus.ERR_o,    0);

        // Reset release with a pending request and no traffic
        rstn = 1;
        tick(1); chk("rel_block_c1", bus.BLOCK_o, 1); chk("rel_enable_c1", bus.ENABLE_o, 0);
        tick(1); chk("rel_enable_c2", bus.ENABLE_o, 1); chk("rel_ack_c2", bus.MODE_ACK_o, 0);
        tick(1); chk("rel_ack_c3", bus.MODE_ACK_o, 1); chk("rel_block_c3", bus.BLOCK_o, 0);
        tick(1); chk("rel_ack_c4", bus.MODE_ACK_o, 0);

        // Reset in the middle of a drain abandons the switch
        bus.MODE_REQ_i = 0;
        tick(1); chk("rd_drain_block", bus.BLOCK_o, 1);
        rstn = 0; bus.MODE_REQ_i = 1;
        #1; chk("rd_rst_enable", bus.ENABLE_o, 0); chk("rd_rst_block", bus.BLOCK_o, 0);
        tick(1); rstn = 1;
        tick(1); chk("rd_fresh_block", bus.BLOCK_o, 1); chk("rd_fresh_enable", bus.ENABLE_o, 0);
        tick(3);

        // Three reads outstanding hold the drain until the last RLAST beat
        reset_with(0);
        bus.ARVALID_i = 1; bus.ARREADY_i = 1;
        tick(3); clear_hs();
        chk("rd3_cnt", bus.RD_CNT_o, 3);
        bus.MODE_REQ_i = 1;
        tick(1); chk("rd3_block", bus.BLOCK_o, 1);
        tick(4); chk("rd3_hold_block", bus.BLOCK_o, 1); chk("rd3_hold_enable", bus.ENABLE_o, 0);
        bus.RVALID_i = 1; bus.RREADY_i = 1; bus.RLAST_i = 1;
        tick(2); bus.RLAST_i = 0;
        tick(1); chk("rd3_nonlast", bus.RD_CNT_o, 1);
        bus.RLAST_i = 1;
        tick(1); clear_hs();
        chk("rd3_cnt0", bus.RD_CNT_o, 0); chk("rd3_enable_pre", bus.ENABLE_o, 0);
        tick(1); chk("rd3_enable", bus.ENABLE_o, 1); chk("rd3_ack_pre", bus.MODE_ACK_o, 0);
        tick(1); chk("rd3_ack", bus.MODE_ACK_o, 1); chk("rd3_unblock", bus.BLOCK_o, 0);
        tick(1);

        // Simultaneous AR and RLAST leave the read count unchanged
        bus.ARVALID_i = 1; bus.ARREADY_i = 1;
        tick(2); chk("same_pre", bus.RD_CNT_o, 2);
        bus.RVALID_i = 1; bus.RREADY_i = 1; bus.RLAST_i = 1;
        tick(1); chk("same_cnt", bus.RD_CNT_o, 2);
        bus.ARVALID_i = 0;
        tick(2); clear_hs();
        chk("same_drained", bus.RD_CNT_o, 0); chk("same_err", bus.ERR_o, 0);

        // Write count saturation
        bus.AWVALID_i = 1; bus.AWREADY_i = 1;
        tick(16);
        chk("sat_cnt16", bus.WR_CNT_o, 16); chk("sat_block", bus.BLOCK_o, 1); chk("sat_err0", bus.ERR_o, 0);
        tick(1); clear_hs();
        chk("sat_cnt17", bus.WR_CNT_o, 16); chk("sat_err1", bus.ERR_o, 1);
        bus.BVALID_i = 1; bus.BREADY_i = 1;
        tick(16); clear_hs();
        chk("sat_empty", bus.WR_CNT_o, 0); chk("sat_unblock", bus.BLOCK_o, 0);
        rstn = 0; bus.MODE_REQ_i = 0;
        tick(1); chk("sat_rst_err", bus.ERR_o, 0);
        rstn = 1;
        tick(1);

        // Request withdrawn during drain: abort without toggle or ACK
        bus.AWVALID_i = 1; bus.AWREADY_i = 1;
        tick(1); clear_hs();
        chk("ab_wr1", bus.WR_CNT_o, 1);
        bus.MODE_REQ_i = 1;
        tick(1); chk("ab_block", bus.BLOCK_o, 1);
        bus.MODE_REQ_i = 0;
        tick(1); chk("ab_unblock", bus.BLOCK_o, 0); chk("ab_enable", bus.ENABLE_o, 0);
        chk("ab_ack1", bus.MODE_ACK_o, 0);
        tick(1); chk("ab_ack2", bus.MODE_ACK_o, 0);

        // Underflow on B sets a sticky error
        bus.BVALID_i = 1; bus.BREADY_i = 1;
        tick(1); chk("uf_wr0", bus.WR_CNT_o, 0); chk("uf_err0", bus.ERR_o, 0);
        tick(1); clear_hs();
        chk("uf_wr_hold", bus.WR_CNT_o, 0); chk("uf_err1", bus.ERR_o, 1);
        tick(5); chk("uf_sticky", bus.ERR_o, 1);
        rstn = 0;
        #1; chk("uf_rst_clear", bus.ERR_o, 0);
        tick(1); rstn = 1;
        tick(1);

        // Drain timeout with one write left outstanding
        bus.AWVALID_i = 1; bus.AWREADY_i = 1;
        tick(1); clear_hs();
        bus.MODE_REQ_i = 1;
        tick(1000); chk("tmo_err0", bus.ERR_o, 0); chk("tmo_block", bus.BLOCK_o, 1);
        tick(30);   chk("tmo_err1", bus.ERR_o, 1); chk("tmo_enable", bus.ENABLE_o, 0);
        bus.BVALID_i = 1; bus.BREADY_i = 1;
        tick(1); clear_hs();
        tick(1); chk("tmo_switch", bus.ENABLE_o, 1);
        tick(3);

        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/conn_mode_ctrl.md
CONN_MODE_CTRL -- requirements
Module: conn_mode_ctrl

Interface
REQ-001 SHALL have parameter MAX_OUTST, default 16, giving the maximum outstanding read or write bursts per direction.
REQ-002 SHALL have parameter DRAIN_TMO, default 1024, giving the cycle limit for draining outstanding bursts.
REQ-003 SHALL have port CLK_i, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port RSTN_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port MODE_REQ_i, input, 1 bit: requested compression mode from CSR (1 = route via AIDC).
REQ-006 SHALL have ports ARVALID_i / ARREADY_i, inputs, 1 bit each: read-address handshake at the XHB side.
REQ-007 SHALL have ports RVALID_i / RREADY_i / RLAST_i, inputs, 1 bit each: read-data handshake and last beat.
REQ-008 SHALL have ports AWVALID_i / AWREADY_i, inputs, 1 bit each: write-address handshake.
REQ-009 SHALL have ports BVALID_i / BREADY_i, inputs, 1 bit each: write-response handshake.
REQ-010 SHALL have port ENABLE_o, output, 1 bit: compression enable driving the AIDC/XHB channel router.
REQ-011 SHALL have port BLOCK_o, output, 1 bit: when 1, the CNN engine holds off new AR/AW issue.
REQ-012 SHALL have port MODE_ACK_o, output, 1 bit: one-cycle pulse on mode-switch completion.
REQ-013 SHALL have ports RD_CNT_o / WR_CNT_o, outputs, CW = $clog2(MAX_OUTST+1) bits each: outstanding read and write burst counts.
REQ-014 SHALL have port ERR_o, output, 1 bit: sticky error flag.

Function
REQ-015 SHALL define the read count as +1 per AR handshake and -1 per R handshake with RLAST_i=1; both events in the same cycle leave it unchanged.
REQ-016 SHALL define the write count as +1 per AW handshake and -1 per B handshake; both events in the same cycle leave it unchanged.
REQ-017 SHALL, on increment at MAX_OUTST, saturate the count and set ERR_o.
REQ-018 SHALL, on decrement at 0, hold the count at 0 and set ERR_o.
REQ-019 SHALL drive BLOCK_o = (state != STABLE) | (RD_CNT_o == MAX_OUTST) | (WR_CNT_o == MAX_OUTST), decoded from registers only.
REQ-020 SHALL use FSM states STABLE, DRAIN, SWITCH.
REQ-021 SHALL, in STABLE, go to DRAIN when MODE_REQ_i != ENABLE_o; otherwise stay in STABLE.
REQ-022 SHALL, in DRAIN, go to SWITCH when both counts are 0 and no AR/AW handshake occurs that cycle.
REQ-023 SHALL, in DRAIN, return to STABLE (abort: no toggle, no ACK) if MODE_REQ_i equals ENABLE_o again; abort takes priority over REQ-022.
REQ-024 SHALL, in DRAIN, count cycles; on reaching DRAIN_TMO it sets ERR_o and remains in DRAIN; the counter is cleared on leaving DRAIN.
REQ-025 SHALL toggle ENABLE_o on the edge entering SWITCH; SWITCH lasts exactly one cycle, then goes to STABLE.
REQ-026 SHALL assert MODE_ACK_o for the single cycle after SWITCH, i.e. the first cycle back in STABLE.
REQ-027 SHALL give this minimum latency with counts at 0: MODE_REQ_i changes in cycle N; BLOCK_o=1 in N+1; ENABLE_o toggles in N+2; MODE_ACK_o=1 and BLOCK_o=0 in N+3.
REQ-028 SHALL ignore MODE_REQ_i changes during SWITCH; a mismatch seen in the following STABLE cycle starts a new DRAIN.
REQ-029 SHALL still count AR/AW handshakes that occur while BLOCK_o=1; these are not flagged as errors.
REQ-030 SHALL keep ERR_o set until reset.

Reset
REQ-031 SHALL, while RSTN_i=0, immediately force state STABLE, ENABLE_o=0, BLOCK_o=0, MODE_ACK_o=0, RD_CNT_o=0, WR_CNT_o=0, ERR_o=0, and timeout count 0.
REQ-032 SHALL, on reset during DRAIN or SWITCH, abandon the switch with no ACK; after release, ENABLE_o=0 and a pending MODE_REQ_i=1 starts a fresh DRAIN.

Structure
REQ-033 SHALL place the FSM state enum and the MAX_OUTST / DRAIN_TMO defaults in shared package conn_pkg.
REQ-034 SHALL implement the saturating up/down counter with error flag as sub-module conn_outst_cnt, instantiated twice (read, write).

Verification
REQ-035 SHALL check: reset release with MODE_REQ_i=1 and no traffic -> BLOCK_o=1 at cycle 1, ENABLE_o=1 at cycle 2, MODE_ACK_o pulse at cycle 3.
REQ-036 SHALL check: 3 AR handshakes, then MODE_REQ_i 0->1 -> DRAIN held; ENABLE_o toggles 1 cycle after the 3rd RLAST beat; ACK follows 1 cycle later.
REQ-037 SHALL check: AR handshake and RLAST handshake in the same cycle with RD_CNT_o=2 -> RD_CNT_o stays 2.
REQ-038 SHALL check: 16 AW handshakes -> WR_CNT_o=16 and BLOCK_o=1; a 17th -> WR_CNT_o=16 and ERR_o=1.
REQ-039 SHALL check: MODE_REQ_i 0->1->0 while WR_CNT_o=1 -> return to STABLE, ENABLE_o=0, no ACK.
REQ-040 SHALL check: B handshake with WR_CNT_o=0 -> ERR_o=1; ERR_o stays set until RSTN_i=0.
